risc_v_mike_uart_mem_bridge: RTL and testbench



---
 rtl/risc_v_mike_pkg.sv | 23 ++
 rtl/risc_v_mike_uart_mem_bridge.sv | 154 +++++++++++++++
 tb/tb_risc_v_mike_uart_mem_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared definitions for the risc_v_mike UART debug bridge.
//   - Command and reply byte constants.
//   - Bridge FSM state encoding.
package risc_v_mike_pkg;

  localparam logic [7:0] BRIDGE_OP_WR = 8'h57;  // 'W'
  localparam logic [7:0] BRIDGE_OP_RD = 8'h52;  // 'R'
  localparam logic [7:0] BRIDGE_ERR   = 8'h3F;  // '?'
  localparam logic [7:0] BRIDGE_ACK   = 8'h4B;  // 'K'

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    W_ADDR = 4'd1,
    W_DATA = 4'd2,
    WRITE  = 4'd3,
    R_ADDR = 4'd4,
    READ   = 4'd5,
    TX     = 4'd6,
    ERR    = 4'd7,
    ACK    = 4'd8
  } bridge_state_t;

endpackage

// File: rtl/risc_v_mike_uart_mem_bridge.sv
// UART-driven debug initiator on the data-memory port.
// Decodes byte commands from the UART receiver:
//   'W' addr d0 d1 d2 d3 : single-word write (LSB first)
//   'R' addr             : single-word read, 4 reply bytes LSB first
// Unknown opcodes are answered with '?'.
// Optional macro RISC_V_MIKE_BRIDGE_ACK_EN: each write is acknowledged with 'K'.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rx_data, rx_valid         received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_ready  reply byte with valid/ready handshake
//   mem_addr, mem_write, mem_wr_data, mem_rd_data  data-memory port
//   bridge_busy               high while a command is in progress
module risc_v_mike_uart_mem_bridge
  import risc_v_mike_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int MEM_ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  output logic        bridge_busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  bridge_state_t          r_state;
  bridge_state_t          w_next;
  logic [MEM_ADDR_W-1:0]  r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_shift;
  logic [1:0]             r_byte_cnt;
  logic [TMO_W-1:0]       r_tmo;
  logic                   w_rx_wait;
  logic                   w_tmo_hit;

  // States that are waiting for the next byte of a command.
  assign w_rx_wait = (r_state == W_ADDR) || (r_state == W_DATA) || (r_state == R_ADDR);
  assign w_tmo_hit = w_rx_wait && !rx_valid && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == BRIDGE_OP_WR)      w_next = W_ADDR;
          else if (rx_data == BRIDGE_OP_RD) w_next = R_ADDR;
          else                              w_next = ERR;
        end
      end
      W_ADDR: begin
        if (rx_valid)       w_next = W_DATA;
        else if (w_tmo_hit) w_next = IDLE;
      end
      W_DATA: begin
        if (rx_valid && (r_byte_cnt == 2'd3)) w_next = WRITE;
        else if (w_tmo_hit)                   w_next = IDLE;
      end
      WRITE: begin
`ifdef RISC_V_MIKE_BRIDGE_ACK_EN
        w_next = ACK;
`else
        w_next = IDLE;
`endif
      end
      R_ADDR: begin
        if (rx_valid)       w_next = READ;
        else if (w_tmo_hit) w_next = IDLE;
      end
      READ: w_next = TX;
      TX: begin
        if (tx_ready && (r_byte_cnt == 2'd3)) w_next = IDLE;
      end
      ERR, ACK: begin
        if (tx_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Address latch, write-word assembly, reply shifter and inter-byte timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_tmo      <= '0;
    end else begin
      unique case (r_state)
        W_ADDR: begin
          if (rx_valid) begin
            r_addr     <= rx_data[MEM_ADDR_W-1:0];
            r_byte_cnt <= 2'd0;
          end
        end
        W_DATA: begin
          if (rx_valid) begin
            r_wdata[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        R_ADDR: begin
          if (rx_valid) r_addr <= rx_data[MEM_ADDR_W-1:0];
        end
        READ: begin
          r_shift    <= mem_rd_data;
          r_byte_cnt <= 2'd0;
        end
        TX: begin
          if (tx_ready) begin
            r_shift    <= {8'h00, r_shift[31:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        default: ;
      endcase

      // Counts idle cycles between bytes; any byte or leaving the wait states clears it.
      if (w_rx_wait && !rx_valid && !w_tmo_hit) r_tmo <= r_tmo + TMO_W'(1);
      else                                      r_tmo <= '0;
    end
  end

  assign mem_addr    = {{(32 - MEM_ADDR_W){1'b0}}, r_addr};
  assign mem_write   = (r_state == WRITE);
  assign mem_wr_data = (r_state == WRITE) ? r_wdata : 32'h0;
  assign tx_valid    = (r_state == TX) || (r_state == ERR) || (r_state == ACK);
  assign bridge_busy = (r_state != IDLE);

  always_comb begin
    tx_data = 8'h00;
    unique case (r_state)
      TX:      tx_data = r_shift[7:0];
      ERR:     tx_data = BRIDGE_ERR;
      ACK:     tx_data = BRIDGE_ACK;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_risc_v_mike_uart_mem_bridge.sv
// Self-checking bench for risc_v_mike_uart_mem_bridge with a small memory model.
module tb_risc_v_mike_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        bridge_busy;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_wr[$];   // {addr[7:0], data[31:0]}
  logic [31:0] mem [0:255];
  logic [31:0] gpio_in0 = 32'hDEADBEEF;
  logic        bp_mode = 1'b0;
  int          bp_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  risc_v_mike_uart_mem_bridge #(.TIMEOUT_CYC(20), .MEM_ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .bridge_busy(bridge_busy)
  );

  always #5 clk = ~clk;

  // Memory model; 0x3E is the GPIO input register.
  assign mem_rd_data = (mem_addr[7:0] == 8'h3E) ? gpio_in0 : mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bridge_busy || exp_tx.size() != 0) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, 32'(n < 1000), 32'd1);
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endfunction

  // Backpressure: one ready cycle per 11 when enabled.
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) begin
      bp_cnt++;
      tx_ready = ((bp_cnt % 11) == 10);
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Output monitor / scoreboard comparison, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (prev_stall && tx_valid) chk("tx_stable", {24'h0, tx_data}, {24'h0, prev_data});
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
      end
      if (mem_write) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
        else begin
          logic [39:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", mem_addr, {24'h0, e[39:32]});
          chk("wr_data", mem_wr_data, e[31:0]);
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0B0C000 | 32'(i);

    // Reset state
    #2;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_busy", {31'h0, bridge_busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Write then read
    exp_wr.push_back({8'h3C, 32'h12345678});
`ifdef RISC_V_MIKE_BRIDGE_ACK_EN
    exp_tx.push_back(8'h4B);
`endif
    send_byte(8'h57);
    chk("busy_after_op", {31'h0, bridge_busy}, 32'h1);
    send_byte(8'h3C); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    chk("wr_latency", {31'h0, mem_write}, 32'h1);
    wait_idle("idle_wr");
    push_word(32'h12345678);
    send_byte(8'h52); send_byte(8'h3C);
    chk("rd_lat_read", {31'h0, tx_valid}, 32'h0);
    @(posedge clk); #1;
    chk("rd_lat_tx", {31'h0, tx_valid}, 32'h1);
    wait_idle("idle_rd");

    // GPIO read
    push_word(32'hDEADBEEF);
    send_byte(8'h52); send_byte(8'h3E);
    wait_idle("idle_gpio");

    // Backpressure with extra rx bytes during TX
    bp_mode = 1'b1;
    push_word(32'hA0B0C007);
    send_byte(8'h52); send_byte(8'h07);
    repeat (3) @(posedge clk);
    send_byte(8'h57); send_byte(8'h00);
    wait_idle("idle_bp");
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Timeout
    send_byte(8'h57); send_byte(8'h05); send_byte(8'hAA);
    repeat (25) @(posedge clk);
    #1 chk("tmo_idle", {31'h0, bridge_busy}, 32'h0);
    push_word(32'hA0B0C005);
    send_byte(8'h52); send_byte(8'h05);
    wait_idle("idle_tmo_rd");

    // Bad opcode
    exp_tx.push_back(8'h3F);
    send_byte(8'h00);
    wait_idle("idle_err");

    // Reset mid-write
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b0;
    #1;
    chk("mrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mrst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("mrst_mem_addr", mem_addr, 32'h0);
    chk("mrst_busy", {31'h0, bridge_busy}, 32'h0);
    chk("mrst_tx_data", {24'h0, tx_data}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Normal read after reset
    push_word(32'h12345678);
    send_byte(8'h52); send_byte(8'h3C);
    wait_idle("idle_final");
    chk("mem_10_untouched", mem[8'h10], 32'hA0B0C010);

    repeat (5) @(posedge clk);
    chk("tx_queue_empty", 32'(exp_tx.size()), 32'h0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
